// File: rtl/rec_play_ctrl.sv
// rtl/rec_play_ctrl.sv - transport FSM and two-cycle SRAM access sequencer for the audio recorder
module rec_play_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int MAX_ADDR = 262143
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_play,
    input  logic              btn_record,
    input  logic              btn_stop,
    input  logic              wr_req,
    input  logic [15:0]       wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   end_addr,
    output logic              play_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REC   = 2'd1,
        S_PLAY  = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(MAX_ADDR);

    state_t            state_q, state_d;
    logic [2:0]        btn_q;
    logic [ADDR_W:0]   addr_q, addr_d, end_q, end_d;
    logic              busy_q, busy_d, dir_q, dir_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d, wr_ack_q, wr_ack_d;
    logic              play_done_q, play_done_d;
    logic              pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic [15:0]       pend_wdata_q, pend_wdata_d;

    logic              stop_e, rec_e, play_e;
    logic              cpl_wr, cpl_rd;
    logic              wr_go, rd_go, rd_mute, wr_keep, rd_keep;
    logic [ADDR_W:0]   addr_inc, addr_c;

    always_comb begin
        stop_e   = btn_stop & ~btn_q[2];
        rec_e    = btn_record & ~btn_q[1] & ~stop_e;
        play_e   = btn_play & ~btn_q[0] & ~stop_e & ~(btn_record & ~btn_q[1]);
        // busy_q marks the strobe cycle, so the next edge always retires the transaction
        cpl_wr   = busy_q & ~dir_q;
        cpl_rd   = busy_q & dir_q;
        addr_inc = addr_q + 1'b1;
        addr_c   = busy_q ? addr_inc : addr_q;

        state_d     = state_q;
        addr_d      = addr_c;
        end_d       = end_q;
        play_done_d = cpl_rd && (addr_inc == end_q);

        case (state_q)
            S_IDLE: begin
                if (rec_e) begin
                    state_d = S_REC;
                    addr_d  = '0;
                end else if (play_e && (end_q != '0)) begin
                    state_d = S_PLAY;
                    addr_d  = '0;
                end
            end
            S_REC: begin
                if (stop_e) begin
                    state_d = S_IDLE;
                    end_d   = addr_c;
                    addr_d  = '0;
                end else if (rec_e) begin
                    addr_d = '0;
                end else if (cpl_wr && (addr_q == LAST)) begin
                    state_d = S_IDLE;
                    end_d   = addr_inc;
                    addr_d  = '0;
                end
            end
            S_PLAY: begin
                if (stop_e || play_done_d) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else if (play_e) begin
                    state_d = S_PAUSE;
                end
            end
            default: begin
                if (stop_e) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else if (play_e) begin
                    state_d = S_PLAY;
                end
            end
        endcase

        mem_wr_d    = 1'b0;
        mem_rd_d    = 1'b0;
        busy_d      = 1'b0;
        dir_d       = dir_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = cpl_wr;
        rd_valid_d  = cpl_rd;
        rd_data_d   = cpl_rd ? mem_rdata : rd_data_q;

        // Never launch on an edge that also leaves the state, so a strobe always retires in-state
        wr_go   = pend_wr_q && !busy_q && (state_q == S_REC) && (state_d == S_REC);
        rd_go   = pend_rd_q && !busy_q && (state_q == S_PLAY) && (state_d == S_PLAY);
        rd_mute = pend_rd_q && (state_q != S_PLAY);

        if (wr_go) begin
            mem_wr_d    = 1'b1;
            busy_d      = 1'b1;
            dir_d       = 1'b0;
            mem_addr_d  = addr_d[ADDR_W-1:0];
            mem_wdata_d = pend_wdata_q;
        end else if (rd_go) begin
            mem_rd_d   = 1'b1;
            busy_d     = 1'b1;
            dir_d      = 1'b1;
            mem_addr_d = addr_d[ADDR_W-1:0];
        end

        if (rd_mute) begin
            rd_valid_d = 1'b1;
            rd_data_d  = '0;
        end

        wr_keep      = pend_wr_q && !wr_go && (state_q == S_REC) && (state_d == S_REC);
        pend_wr_d    = wr_keep || (wr_req && (state_q == S_REC));
        pend_wdata_d = (wr_req && !wr_keep) ? wr_data : pend_wdata_q;
        rd_keep      = pend_rd_q && !rd_go && !rd_mute;
        pend_rd_d    = rd_keep || rd_req;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            btn_q        <= '0;
            addr_q       <= '0;
            end_q        <= '0;
            busy_q       <= 1'b0;
            dir_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wdata_q  <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            play_done_q  <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_rd_q    <= 1'b0;
            pend_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            btn_q        <= {btn_stop, btn_record, btn_play};
            addr_q       <= addr_d;
            end_q        <= end_d;
            busy_q       <= busy_d;
            dir_q        <= dir_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_q     <= mem_wr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            wr_ack_q     <= wr_ack_d;
            play_done_q  <= play_done_d;
            pend_wr_q    <= pend_wr_d;
            pend_rd_q    <= pend_rd_d;
            pend_wdata_q <= pend_wdata_d;
        end
    end

    assign state     = state_q;
    assign end_addr  = end_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_ack    = wr_ack_q;
    assign play_done = play_done_q;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// tb/tb_rec_play_ctrl.sv - self-checking bench for rec_play_ctrl
module tb_rec_play_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_play = 1'b0, btn_record = 1'b0, btn_stop = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0;
    logic [15:0] wr_data = '0;

    logic        wr_ack, rd_valid, mem_wr, mem_rd, play_done;
    logic [15:0] rd_data, mem_wdata, mem_rdata;
    logic [17:0] mem_addr;
    logic [1:0]  state;
    logic [18:0] end_addr;

    logic        wr_ack_s, rd_valid_s, mem_wr_s, mem_rd_s, play_done_s;
    logic [15:0] rd_data_s, mem_wdata_s, mem_rdata_s;
    logic [17:0] mem_addr_s;
    logic [1:0]  state_s;
    logic [18:0] end_addr_s;

    always #5 clk = ~clk;

    rec_play_ctrl #(.ADDR_W(18), .MAX_ADDR(262143)) dut (
        .clk(clk), .reset(reset), .btn_play(btn_play), .btn_record(btn_record), .btn_stop(btn_stop),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack), .rd_req(rd_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state(state), .end_addr(end_addr),
        .play_done(play_done)
    );

    rec_play_ctrl #(.ADDR_W(18), .MAX_ADDR(3)) dut_s (
        .clk(clk), .reset(reset), .btn_play(btn_play), .btn_record(btn_record), .btn_stop(btn_stop),
        .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack_s), .rd_req(rd_req), .rd_data(rd_data_s),
        .rd_valid(rd_valid_s), .mem_addr(mem_addr_s), .mem_wr(mem_wr_s), .mem_rd(mem_rd_s),
        .mem_wdata(mem_wdata_s), .mem_rdata(mem_rdata_s), .state(state_s), .end_addr(end_addr_s),
        .play_done(play_done_s)
    );

    logic [15:0] sram   [0:262143];
    logic [15:0] sram_s [0:3];
    assign mem_rdata   = sram[mem_addr];
    assign mem_rdata_s = sram_s[mem_addr_s[1:0]];

    always @(posedge clk) begin
        if (mem_wr)   sram[mem_addr] <= mem_wdata;
        if (mem_wr_s) sram_s[mem_addr_s[1:0]] <= mem_wdata_s;
    end

    int          n_ack = 0, n_done = 0, n_wr_s = 0, n_ack_s = 0, mon_bad = 0;
    logic        prev_wr = 1'b0, prev_rd = 1'b0;
    logic [15:0] rdq [$];

    always @(negedge clk) begin
        if (wr_ack)    n_ack   <= n_ack + 1;
        if (play_done) n_done  <= n_done + 1;
        if (mem_wr_s)  n_wr_s  <= n_wr_s + 1;
        if (wr_ack_s)  n_ack_s <= n_ack_s + 1;
        if (rd_valid)  rdq.push_back(rd_data);
        if ((mem_wr && mem_rd) || (mem_wr && prev_wr) || (mem_rd && prev_rd))
            mon_bad <= mon_bad + 1;
        prev_wr <= mem_wr;
        prev_rd <= mem_rd;
    end

    int total = 0, bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic p, input logic r, input logic s);
        btn_play = p; btn_record = r; btn_stop = s;
        tick();
        btn_play = 1'b0; btn_record = 1'b0; btn_stop = 1'b0;
        tick();
    endtask

    task automatic pulse_wr(input logic [15:0] d);
        wr_data = d; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    typedef struct {
        logic       p, r, s;
        logic [1:0] exp_state;
        int         exp_end;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          a0, a1, q0, d0, k, pause_at;
        logic [15:0] d;
        logic [15:0] model [$];
        logic [15:0] expq [$];

        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 2'd0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 2'd1, 0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 2'd1, 0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 2'd1, 0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd0, 0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 2'd0, 0};

        repeat (3) tick();
        check("reset strobes/pulses", {mem_wr, mem_rd, wr_ack, rd_valid, play_done}, 0);
        reset = 1'b1;
        tick();
        check("reset state", state, 0);
        check("reset end_addr", end_addr, 0);
        check("reset rd_data", rd_data, 0);

        for (int i = 0; i < 7; i++) begin
            press(tbl[i].p, tbl[i].r, tbl[i].s);
            check($sformatf("vec%0d state", i), state, tbl[i].exp_state);
            check($sformatf("vec%0d end_addr", i), end_addr, tbl[i].exp_end);
        end

        press(1'b0, 1'b1, 1'b0);
        pulse_wr(16'hdead);
        tick();
        check("t1 write strobe", mem_wr, 1);
        #2 reset = 1'b0;
        #1;
        check("t1 async clear", {mem_wr, mem_rd, wr_ack, rd_valid, play_done, state}, 0);
        check("t1 async clear data", {mem_wdata, rd_data}, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("t1 state after release", state, 0);
        check("t1 end_addr after release", end_addr, 0);

        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            pulse_wr(16'h1111 * 16'(i + 1));
            tick();
            check($sformatf("t2 mem_wr %0d", i), {mem_wr, mem_rd}, 2'b10);
            check($sformatf("t2 mem_addr %0d", i), mem_addr, i);
            check($sformatf("t2 mem_wdata %0d", i), mem_wdata, 16'h1111 * 16'(i + 1));
            tick();
            check($sformatf("t2 wr_ack %0d", i), {wr_ack, mem_wr}, 2'b10);
            tick();
        end
        press(1'b0, 1'b0, 1'b1);
        check("t2 end_addr", end_addr, 5);
        check("t2 state", state, 0);

        press(1'b1, 1'b0, 1'b0);
        check("t3 state play", state, 2);
        for (int i = 0; i < 5; i++) begin
            pulse_rd();
            tick();
            check($sformatf("t3 mem_rd %0d", i), {mem_rd, mem_wr}, 2'b10);
            check($sformatf("t3 mem_addr %0d", i), mem_addr, i);
            tick();
            check($sformatf("t3 rd_valid %0d", i), rd_valid, 1);
            check($sformatf("t3 rd_data %0d", i), rd_data, 16'h1111 * 16'(i + 1));
            check($sformatf("t3 play_done %0d", i), play_done, (i == 4) ? 1 : 0);
            tick();
        end
        check("t3 state end", state, 0);

        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            pulse_rd(); tick(); tick();
            check($sformatf("t4 rd_data %0d", i), rd_data, 16'h1111 * 16'(i + 1));
            tick();
        end
        press(1'b1, 1'b0, 1'b0);
        check("t4 state pause", state, 3);
        pulse_rd();
        tick();
        check("t4 silence valid", {rd_valid, mem_rd}, 2'b10);
        check("t4 silence data", rd_data, 0);
        tick();
        press(1'b1, 1'b0, 1'b0);
        check("t4 state resume", state, 2);
        pulse_rd();
        tick();
        check("t4 resume addr", mem_addr, 2);
        tick();
        check("t4 resume data", rd_data, 16'h3333);
        press(1'b0, 1'b0, 1'b1);
        check("t4 stop state", state, 0);

        a0 = n_wr_s; a1 = n_ack_s;
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            pulse_wr(16'ha000 + 16'(i));
            repeat (3) tick();
        end
        check("t5 small writes", n_wr_s - a0, 4);
        check("t5 small acks", n_ack_s - a1, 4);
        check("t5 small state", state_s, 0);
        check("t5 small end_addr", end_addr_s, 4);
        check("t5 small last word", sram_s[3], 16'ha003);
        press(1'b0, 1'b0, 1'b1);
        check("t5 main end_addr", end_addr, 6);

        press(1'b0, 1'b1, 1'b0);
        wr_data = 16'hbeef; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        check("t6 silence in record", {rd_valid, mem_rd, mem_wr}, 3'b101);
        check("t6 silence data", rd_data, 0);
        tick();
        check("t6 write ack", wr_ack, 1);
        tick();
        press(1'b0, 1'b0, 1'b1);
        check("t6 end_addr", end_addr, 1);

        a0 = n_ack;
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wr_data = 16'(i + 1); wr_req = 1'b1;
            tick();
        end
        wr_req = 1'b0;
        repeat (6) tick();
        check("busy drop acks", n_ack - a0, 2);
        check("busy drop word1", sram[1], 16'h0002);
        press(1'b0, 1'b0, 1'b1);
        check("busy drop end_addr", end_addr, 2);

        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, 12);
            model = {};
            expq = {};
            a0 = n_ack;
            press(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < k; i++) begin
                d = 16'($urandom);
                model.push_back(d);
                pulse_wr(d);
                repeat ($urandom_range(1, 6)) tick();
            end
            repeat (4) tick();
            press(1'b0, 1'b0, 1'b1);
            check("rnd end_addr", end_addr, k);
            check("rnd acks", n_ack - a0, k);

            q0 = rdq.size();
            d0 = n_done;
            pause_at = $urandom_range(0, k - 1);
            press(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < k; i++) begin
                if (i == pause_at) begin
                    repeat (3) tick();
                    press(1'b1, 1'b0, 1'b0);
                    pulse_rd();
                    repeat (3) tick();
                    expq.push_back(16'h0000);
                    press(1'b1, 1'b0, 1'b0);
                end
                pulse_rd();
                expq.push_back(model[i]);
                repeat ($urandom_range(1, 6)) tick();
            end
            repeat (4) tick();
            check("rnd state after play", state, 0);
            check("rnd play_done count", n_done - d0, 1);
            pulse_rd();
            repeat (3) tick();
            expq.push_back(16'h0000);
            check("rnd rd_valid count", rdq.size() - q0, expq.size());
            for (int j = 0; j < expq.size(); j++) begin
                if (q0 + j < rdq.size())
                    check($sformatf("rnd%0d sample %0d", r, j), rdq[q0 + j], expq[j]);
            end
        end

        check("strobe monitor", mon_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
